instr_encoder_loader: RTL and testbench

Packs decoded instruction fields (opcode, rz, rx, ry, immediate, address, jump target) into the 24-bit instruction word format consumed by the instruction register, and writes the words into the 64-entry program memory. It sits between a host/boot sequencer and the program memory write port. A 4-deep FIFO decouples field submission from memory back-pressure. A small FSM handles sequencing: load, flush, done.

---
 rtl/instr_encoder_loader.sv | 163 ++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes instruction field bundles into 24-bit words and streams them into program memory
// A small word FIFO decouples field submission from memory back-pressure; the FSM sequences load/flush/done.
module instr_encoder_loader #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [5:0]  i_base_addr,
  input  logic        i_finish,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [3:0]  i_opcode,
  input  logic [3:0]  i_rz,
  input  logic [3:0]  i_rx,
  input  logic [3:0]  i_ry,
  input  logic [15:0] i_immediate,
  input  logic [15:0] i_address,
  input  logic [5:0]  i_jmp_addrs,
  output logic        o_mem_we,
  input  logic        i_mem_ready,
  output logic [5:0]  o_mem_addr,
  output logic [23:0] o_mem_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_full,
  output logic        o_err,
  output logic [6:0]  o_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] OCC_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [5:0]  LAST_ADDR = 6'd63;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [23:0]   r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_occ;
  logic [5:0]    r_acc_ptr;
  logic [5:0]    r_wr_ptr;
  logic [6:0]    r_count;
  logic          r_err;
  logic          r_full;

  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_reject;
  logic          w_push;
  logic          w_pop;
  logic          w_start_ok;
  logic [23:0]   w_word;

  assign w_fifo_full  = (r_occ == OCC_FULL);
  assign w_fifo_empty = (r_occ == '0);
  assign w_accept     = i_in_valid && w_in_ready;
  // WRTD only carries an 8-bit immediate; a non-zero upper byte is consumed but dropped.
  assign w_reject     = w_accept && (i_opcode == 4'h0) && (i_immediate[15:8] != 8'h00);
  assign w_push       = w_accept && !w_reject;
  assign w_pop        = !w_fifo_empty && i_mem_ready;
  assign w_start_ok   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_comb begin
    w_word = 24'h000000;
    if (i_opcode == 4'h0)
      w_word = {i_opcode, i_rz, i_immediate[7:0], 8'h00};
    else if (i_opcode <= 4'h7)
      w_word = {i_opcode, i_rz, i_rx, i_ry, 8'h00};
    else if (i_opcode <= 4'hB)
      w_word = {i_opcode, i_rz, 16'h0000};
    else if (i_opcode == 4'hC)
      w_word = {i_opcode, i_rz, i_immediate};
    else if (i_opcode != 4'hF)
      w_word = {i_opcode, i_rz, i_address};
    else
      w_word = {i_opcode, i_jmp_addrs, 14'h0000};
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_in_ready = !w_fifo_full;
        o_busy     = 1'b1;
        if (i_finish || (w_push && (r_acc_ptr == LAST_ADDR))) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        o_busy = 1'b1;
        if (w_fifo_empty || ((r_occ == (PW+1)'(1)) && w_pop)) w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        if (w_start_ok) w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_tail] <= w_word;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      if (w_push && !w_pop)      r_occ <= r_occ + 1'b1;
      else if (!w_push && w_pop) r_occ <= r_occ - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_acc_ptr <= 6'd0;
      r_wr_ptr  <= 6'd0;
      r_count   <= 7'd0;
      r_err     <= 1'b0;
      r_full    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start_ok) begin
        r_acc_ptr <= i_base_addr;
        r_wr_ptr  <= i_base_addr;
        r_count   <= 7'd0;
        r_err     <= 1'b0;
        r_full    <= 1'b0;
      end else begin
        // Pointers saturate at the last address instead of wrapping.
        if (w_push && (r_acc_ptr != LAST_ADDR)) r_acc_ptr <= r_acc_ptr + 6'd1;
        if (w_push && (r_acc_ptr == LAST_ADDR)) r_full <= 1'b1;
        if (w_reject) r_err <= 1'b1;
        if (w_pop) begin
          r_count <= r_count + 7'd1;
          if (r_wr_ptr != LAST_ADDR) r_wr_ptr <= r_wr_ptr + 6'd1;
        end
      end
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_mem_we    = !w_fifo_empty;
  assign o_mem_addr  = r_wr_ptr;
  assign o_mem_wdata = w_fifo_empty ? 24'h000000 : r_fifo[r_head];
  assign o_full      = r_full;
  assign o_err       = r_err;
  assign o_count     = r_count;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  base_addr;
  logic        finish;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode, rz, rx, ry;
  logic [15:0] immediate, address;
  logic [5:0]  jmp_addrs;
  logic        mem_we;
  logic        mem_ready;
  logic [5:0]  mem_addr;
  logic [23:0] mem_wdata;
  logic        busy, done, full, err;
  logic [6:0]  count;

  typedef struct {
    logic [3:0]  op, rz, rx, ry;
    logic [15:0] imm, addr;
    logic [5:0]  jmp;
  } bundle_t;

  bundle_t     b [8];
  logic [29:0] wlog [$];
  int          checks = 0;
  int          failures = 0;
  int          off_idx = 0;
  int          n_acc;

  instr_encoder_loader #(.FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_addr),
    .i_finish(finish), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_opcode(opcode), .i_rz(rz), .i_rx(rx), .i_ry(ry),
    .i_immediate(immediate), .i_address(address), .i_jmp_addrs(jmp_addrs),
    .o_mem_we(mem_we), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_busy(busy), .o_done(done), .o_full(full),
    .o_err(err), .o_count(count)
  );

  always #5 clk = ~clk;

  // Records every completed memory write as {addr, word}.
  always @(negedge clk) begin
    if (!rst && mem_we && mem_ready) wlog.push_back({mem_addr, mem_wdata});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [29:0] exp);
    logic [29:0] obs;
    obs = (idx < wlog.size()) ? wlog[idx] : 30'bx;
    chk(tag, {2'b00, obs}, {2'b00, exp});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {26'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, {8'd0, mem_wdata}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_full"}, {31'd0, full}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_count"}, {25'd0, count}, 32'd0);
  endtask

  task automatic set_b(input int i, input logic [3:0] op, input logic [3:0] z, input logic [3:0] x,
                       input logic [3:0] y, input logic [15:0] im, input logic [15:0] ad, input logic [5:0] j);
    b[i].op = op; b[i].rz = z; b[i].rx = x; b[i].ry = y;
    b[i].imm = im; b[i].addr = ad; b[i].jmp = j;
  endtask

  task automatic do_start(input logic [5:0] base);
    wlog.delete();
    off_idx   = 0;
    base_addr = base;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic do_finish();
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  // Presents b[off_idx..n-1] for at most max_cycles cycles, advancing on each handshake.
  task automatic run_offer(input int n, input int max_cycles);
    logic acc;
    for (int c = 0; c < max_cycles; c++) begin
      in_valid = (off_idx < n);
      if (off_idx < n) begin
        opcode = b[off_idx].op; rz = b[off_idx].rz; rx = b[off_idx].rx; ry = b[off_idx].ry;
        immediate = b[off_idx].imm; address = b[off_idx].addr; jmp_addrs = b[off_idx].jmp;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) off_idx++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    for (int c = 0; c < max_cycles && !done; c++) tick();
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = 6'd0; finish = 1'b0; in_valid = 1'b0;
    opcode = 4'h0; rz = 4'h0; rx = 4'h0; ry = 4'h0;
    immediate = 16'h0; address = 16'h0; jmp_addrs = 6'd0; mem_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_reset_outputs("rst0");

    // Single ADD: one-cycle latency to write request.
    do_start(6'd0);
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_addr_base", {26'd0, mem_addr}, 32'd0);
    in_valid = 1'b1; opcode = 4'h1; rz = 4'd3; rx = 4'd1; ry = 4'd2;
    tick();
    in_valid = 1'b0;
    chk("t1_mem_we", {31'd0, mem_we}, 32'd1);
    chk("t1_wdata", {8'd0, mem_wdata}, 32'h131200);
    chk("t1_addr", {26'd0, mem_addr}, 32'd0);
    tick();
    chk("t1_count", {25'd0, count}, 32'd1);
    chk("t1_we_low", {31'd0, mem_we}, 32'd0);
    do_finish();
    chk("t1_flush_busy", {31'd0, busy}, 32'd1);
    chk("t1_flush_notdone", {31'd0, done}, 32'd0);
    tick();
    chk("t1_done", {31'd0, done}, 32'd1);

    // Mixed formats back to back.
    set_b(0, 4'h0, 4'd2, 4'd0, 4'd0, 16'h005A, 16'h0, 6'd0);
    set_b(1, 4'hC, 4'd4, 4'd0, 4'd0, 16'hBEEF, 16'h0, 6'd0);
    set_b(2, 4'hF, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0, 6'd37);
    set_b(3, 4'hB, 4'd7, 4'd0, 4'd0, 16'h0000, 16'h0, 6'd0);
    do_start(6'd0);
    run_offer(4, 4);
    chk("t2_acc", off_idx, 4);
    do_finish();
    wait_done("t2_done", 20);
    chk("t2_nwr", wlog.size(), 4);
    chk_log("t2_w0", 0, {6'd0, 24'h025A00});
    chk_log("t2_w1", 1, {6'd1, 24'hC4BEEF});
    chk_log("t2_w2", 2, {6'd2, 24'hF94000});
    chk_log("t2_w3", 3, {6'd3, 24'hB70000});
    chk("t2_count", {25'd0, count}, 32'd4);

    // Back-pressure: FIFO fills at 4, then drains in order.
    for (int i = 0; i < 6; i++)
      set_b(i, 4'(i + 1), 4'(i), 4'(i + 1), 4'(i + 2), 16'h0, 16'h0, 6'd0);
    mem_ready = 1'b0;
    do_start(6'd10);
    run_offer(6, 6);
    chk("t3_acc4", off_idx, 4);
    chk("t3_in_ready0", {31'd0, in_ready}, 32'd0);
    chk("t3_we_held", {31'd0, mem_we}, 32'd1);
    chk("t3_wdata_held", {8'd0, mem_wdata}, 32'h101200);
    chk("t3_addr_held", {26'd0, mem_addr}, 32'd10);
    mem_ready = 1'b1;
    run_offer(6, 12);
    chk("t3_acc6", off_idx, 6);
    do_finish();
    wait_done("t3_done", 20);
    chk("t3_nwr", wlog.size(), 6);
    chk_log("t3_w0", 0, {6'd10, 24'h101200});
    chk_log("t3_w1", 1, {6'd11, 24'h212300});
    chk_log("t3_w2", 2, {6'd12, 24'h323400});
    chk_log("t3_w3", 3, {6'd13, 24'h434500});
    chk_log("t3_w4", 4, {6'd14, 24'h545600});
    chk_log("t3_w5", 5, {6'd15, 24'h656700});
    chk("t3_count", {25'd0, count}, 32'd6);

    // End of memory: stop at address 63.
    set_b(0, 4'hC, 4'd1, 4'd0, 4'd0, 16'h1234, 16'h0, 6'd0);
    set_b(1, 4'hD, 4'd2, 4'd0, 4'd0, 16'h0, 16'hABCD, 6'd0);
    set_b(2, 4'hE, 4'd3, 4'd0, 4'd0, 16'h0, 16'h5555, 6'd0);
    do_start(6'd62);
    run_offer(3, 6);
    chk("t4_acc2", off_idx, 2);
    wait_done("t4_done", 20);
    chk("t4_full", {31'd0, full}, 32'd1);
    chk("t4_count", {25'd0, count}, 32'd2);
    chk("t4_nwr", wlog.size(), 2);
    chk_log("t4_w0", 0, {6'd62, 24'hC11234});
    chk_log("t4_w1", 1, {6'd63, 24'hD2ABCD});
    chk("t4_addr_sat", {26'd0, mem_addr}, 32'd63);

    // Rejected WRTD: err set, only the ADD lands at base.
    set_b(0, 4'h0, 4'd1, 4'd0, 4'd0, 16'h0100, 16'h0, 6'd0);
    set_b(1, 4'h1, 4'd5, 4'd6, 4'd7, 16'h0, 16'h0, 6'd0);
    do_start(6'd20);
    chk("t5_err_clear", {31'd0, err}, 32'd0);
    run_offer(1, 1);
    chk("t5_err_set", {31'd0, err}, 32'd1);
    chk("t5_no_push", {31'd0, mem_we}, 32'd0);
    run_offer(2, 1);
    do_finish();
    wait_done("t5_done", 20);
    chk("t5_nwr", wlog.size(), 1);
    chk_log("t5_w0", 0, {6'd20, 24'h156700});
    chk("t5_err_hold", {31'd0, err}, 32'd1);
    chk("t5_count", {25'd0, count}, 32'd1);

    // Reset mid-load with queued words.
    for (int i = 0; i < 3; i++)
      set_b(i, 4'h2, 4'(i), 4'd1, 4'd1, 16'h0, 16'h0, 6'd0);
    mem_ready = 1'b0;
    do_start(6'd5);
    chk("t6_err_cleared", {31'd0, err}, 32'd0);
    run_offer(3, 3);
    chk("t6_we_pending", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("t6_rst");
    mem_ready = 1'b1;
    tick(); tick(); tick();
    chk("t6_no_write", wlog.size(), 0);
    chk("t6_we_idle", {31'd0, mem_we}, 32'd0);
    set_b(0, 4'h1, 4'd3, 4'd1, 4'd2, 16'h0, 16'h0, 6'd0);
    do_start(6'd0);
    run_offer(1, 1);
    do_finish();
    wait_done("t6_done", 20);
    chk("t6_nwr", wlog.size(), 1);
    chk_log("t6_w0", 0, {6'd0, 24'h131200});
    chk("t6_count", {25'd0, count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
